// File: rtl/duck_pkg.sv
// Shared state encoding, VGA frame constants and bit-search helper for the
// light-gun hit sequencer.
package duck_pkg;

   localparam int H_TOTAL = 800;
   localparam int V_TOTAL = 525;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_BLACK   = 3'd2;
   localparam logic [2:0] ST_FLASH   = 3'd3;
   localparam logic [2:0] ST_RESOLVE = 3'd4;
   localparam logic [2:0] ST_RELEASE = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_ARM     = ST_ARM,
      S_BLACK   = ST_BLACK,
      S_FLASH   = ST_FLASH,
      S_RESOLVE = ST_RESOLVE,
      S_RELEASE = ST_RELEASE
   } state_e;

   // Returns {found, index} of the lowest set bit of mask at or above start.
   function automatic logic [3:0] find_set_from(input logic [7:0] mask, input logic [3:0] start);
      logic [3:0] res;
      res = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i] && (4'(i) >= start)) begin
            res = {1'b1, 3'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by an optional stable-count filter; with
// DEBOUNCE_CYCLES == 0 the output is the bare synchronised input.
module input_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic db_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign db_o = sync_q;
      end else begin : g_filter
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          db_q, db_d;

         // Accept a new level only after it has differed for the full window.
         always_comb begin
            cnt_d = cnt_q;
            db_d  = db_q;
            if (sync_q != db_q) begin
               if (cnt_q == LAST) begin
                  db_d  = sync_q;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               cnt_q <= '0;
               db_q  <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               db_q  <= db_d;
            end
         end

         assign db_o = db_q;
      end
   endgenerate

endmodule

// File: rtl/gun_hit_sequencer.sv
// Light-gun hit resolver: on a debounced press it flashes one black frame and
// then one frame per live target, counting photodiode activity to build a hit mask.
module gun_hit_sequencer
   import duck_pkg::*;
#(
   parameter int  NUM_TARGETS     = 2,
   parameter int  DEBOUNCE_CYCLES = 250000,
   parameter int  DETECT_MIN      = 64,
   parameter int  CNT_W           = 12,
   localparam int IDX_W           = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   trigger,
   input  logic                   detect,
   input  logic                   frame_start,
   input  logic [NUM_TARGETS-1:0] target_live,
   output logic                   flash_black,
   output logic                   flash_valid,
   output logic [IDX_W-1:0]       flash_idx,
   output logic                   hit_valid,
   output logic [NUM_TARGETS-1:0] hit_mask,
   output logic                   miss,
   output logic                   busy,
   output logic                   debug
);

   localparam logic [CNT_W-1:0] DET_MIN_C = CNT_W'(DETECT_MIN);

   logic trig_db_s;
   logic det_s;
   logic press_s;
   logic cnt_hit_s;
   logic [7:0] live_pad_s;
   logic [3:0] first_s;
   logic [3:0] nxt_s;

   state_e                 state_q, state_d;
   logic [NUM_TARGETS-1:0] live_q, live_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_TARGETS-1:0] mask_next_q, mask_next_d;
   logic                   trig_prev_q;

   logic                   flash_black_q, flash_black_d;
   logic                   flash_valid_q, flash_valid_d;
   logic [IDX_W-1:0]       flash_idx_q, flash_idx_d;
   logic                   hit_valid_q, hit_valid_d;
   logic [NUM_TARGETS-1:0] hit_mask_q, hit_mask_d;
   logic                   miss_q, miss_d;
   logic                   busy_q, busy_d;

   input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig_db (
      .clk   (clk),
      .reset (reset),
      .din   (trigger),
      .db_o  (trig_db_s)
   );

   input_debounce #(.DEBOUNCE_CYCLES(0)) u_det_sync (
      .clk   (clk),
      .reset (reset),
      .din   (detect),
      .db_o  (det_s)
   );

   assign press_s   = trig_db_s & ~trig_prev_q;
   assign cnt_hit_s = (cnt_q >= DET_MIN_C);
   assign first_s   = find_set_from(live_pad_s, 4'd0);
   assign nxt_s     = find_set_from(live_pad_s, 4'(idx_q) + 4'd1);

   always_comb begin
      live_pad_s = 8'd0;
      live_pad_s[NUM_TARGETS-1:0] = live_q;
   end

   // Per-frame photodiode counter; a frame boundary clears it before any increment.
   always_comb begin
      if (frame_start) begin
         cnt_d = '0;
      end else if ((state_q == S_BLACK || state_q == S_FLASH) && det_s && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      live_d      = live_q;
      idx_d       = idx_q;
      mask_next_d = mask_next_q;
      case (state_q)
         S_IDLE: begin
            if (press_s) begin
               live_d      = target_live;
               idx_d       = '0;
               mask_next_d = '0;
               if (target_live == '0) begin
                  state_d = S_RESOLVE;
               end else begin
                  state_d = S_ARM;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARM: begin
            if (frame_start) begin
               state_d = S_BLACK;
            end else begin
               state_d = S_ARM;
            end
         end
         S_BLACK: begin
            // Light during the black frame means the gun sees a lamp, not a target.
            if (frame_start) begin
               if (cnt_hit_s || !first_s[3]) begin
                  state_d = S_RESOLVE;
               end else begin
                  idx_d   = IDX_W'(first_s[2:0]);
                  state_d = S_FLASH;
               end
            end else begin
               state_d = S_BLACK;
            end
         end
         S_FLASH: begin
            if (frame_start) begin
               mask_next_d[idx_q] = cnt_hit_s;
               if (nxt_s[3]) begin
                  idx_d   = IDX_W'(nxt_s[2:0]);
                  state_d = S_FLASH;
               end else begin
                  state_d = S_RESOLVE;
               end
            end else begin
               state_d = S_FLASH;
            end
         end
         S_RESOLVE: begin
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!trig_db_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RELEASE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they align with state_q.
   always_comb begin
      flash_black_d = (state_d == S_BLACK);
      flash_valid_d = (state_d == S_FLASH);
      busy_d        = (state_d != S_IDLE);
      hit_valid_d   = (state_d == S_RESOLVE);
      if (state_d == S_FLASH) begin
         flash_idx_d = idx_d;
      end else begin
         flash_idx_d = '0;
      end
      if (state_d == S_RESOLVE) begin
         hit_mask_d = mask_next_d;
         miss_d     = (mask_next_d == '0);
      end else begin
         hit_mask_d = hit_mask_q;
         miss_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         live_q        <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         mask_next_q   <= '0;
         trig_prev_q   <= 1'b0;
         flash_black_q <= 1'b0;
         flash_valid_q <= 1'b0;
         flash_idx_q   <= '0;
         hit_valid_q   <= 1'b0;
         hit_mask_q    <= '0;
         miss_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         live_q        <= live_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         mask_next_q   <= mask_next_d;
         trig_prev_q   <= trig_db_s;
         flash_black_q <= flash_black_d;
         flash_valid_q <= flash_valid_d;
         flash_idx_q   <= flash_idx_d;
         hit_valid_q   <= hit_valid_d;
         hit_mask_q    <= hit_mask_d;
         miss_q        <= miss_d;
         busy_q        <= busy_d;
      end
   end

   assign flash_black = flash_black_q;
   assign flash_valid = flash_valid_q;
   assign flash_idx   = flash_idx_q;
   assign hit_valid   = hit_valid_q;
   assign hit_mask    = hit_mask_q;
   assign miss        = miss_q;
   assign busy        = busy_q;
   assign debug       = det_s;

endmodule

// File: tb/tb_gun_hit_sequencer.sv
// Directed and randomized shots against a frame-level model of the flash sequence.
module tb_gun_hit_sequencer;
   import duck_pkg::*;

   localparam int NT        = 2;
   localparam int DMIN      = 64;
   localparam int FRAME_LEN = H_TOTAL / 4;
   localparam int DET_START = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          trigger;
   logic          detect;
   logic          frame_start;
   logic [NT-1:0] target_live;
   logic          flash_black;
   logic          flash_valid;
   logic [0:0]    flash_idx;
   logic          hit_valid;
   logic [NT-1:0] hit_mask;
   logic          miss;
   logic          busy;
   logic          debug;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   ph = 0;
   int   hv_count = 0;
   int   busy_rises = 0;
   logic busy_prev = 1'b0;
   int   det_lo = 0;
   int   det_hi = 0;
   logic det_force = 1'b0;
   logic last_det = 1'b0;
   logic rst_ok = 1'b0;
   int   dbg_bad = 0;

   always #5 clk = ~clk;

   gun_hit_sequencer #(
      .NUM_TARGETS(NT), .DEBOUNCE_CYCLES(4), .DETECT_MIN(DMIN), .CNT_W(12)
   ) dut (
      .clk(clk), .reset(reset), .trigger(trigger), .detect(detect),
      .frame_start(frame_start), .target_live(target_live),
      .flash_black(flash_black), .flash_valid(flash_valid), .flash_idx(flash_idx),
      .hit_valid(hit_valid), .hit_mask(hit_mask), .miss(miss), .busy(busy), .debug(debug)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: frame_start on phase 0, detect inside the current window.
   task automatic step();
      frame_start = (ph == 0);
      detect = det_force | ((ph >= det_lo) && (ph < det_hi));
      @(posedge clk);
      #1;
      ph = (ph + 1) % FRAME_LEN;
      if (rst_ok && reset === 1'b1 && debug !== last_det) dbg_bad++;
      rst_ok = (reset === 1'b1);
      last_det = detect;
      if (hit_valid === 1'b1) hv_count++;
      if (busy === 1'b1 && busy_prev === 1'b0) busy_rises++;
      busy_prev = busy;
   endtask

   task automatic press(input string tag);
      int n = 0;
      trigger = 1'b1;
      while (busy !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check({tag, " busy rise"}, 32'(busy), 32'd1);
   endtask

   task automatic arm_walk(input string tag);
      int   bad = 0;
      int   n = 0;
      logic was_fs = 1'b0;
      while (!was_fs && n <= FRAME_LEN + 1) begin
         if (flash_black !== 1'b0 || flash_valid !== 1'b0 || hit_valid !== 1'b0) bad++;
         was_fs = (ph == 0);
         step();
         n++;
      end
      check({tag, " arm quiet"}, 32'(bad), 32'd0);
   endtask

   // Called right after the frame_start edge; runs to the next frame boundary.
   task automatic frame_body(input string tag, input logic eb, input logic ev, input int ei, input int n);
      int bad = 0;
      det_lo = DET_START;
      det_hi = DET_START + n;
      if (flash_black !== eb || flash_valid !== ev || 32'(flash_idx) !== 32'(ei) || hit_valid !== 1'b0) bad++;
      while (ph != 0) begin
         step();
         if (flash_black !== eb || flash_valid !== ev || 32'(flash_idx) !== 32'(ei) || hit_valid !== 1'b0) bad++;
      end
      det_lo = 0;
      det_hi = 0;
      check({tag, " frame"}, 32'(bad), 32'd0);
   endtask

   task automatic run_shot(input string tag, input logic [NT-1:0] live, input logic [NT-1:0] live_after,
                           input int black_n, input int c0, input int c1, input int hold, input logic force_det);
      int            cnt [NT];
      logic [NT-1:0] exp_mask;
      logic          cheat;
      int            hv0, br0, n;
      cnt[0] = c0;
      cnt[1] = c1;
      hv0 = hv_count;
      br0 = busy_rises;
      cheat = (live != '0) && (force_det || black_n >= DMIN);
      exp_mask = '0;
      if (live != '0 && !cheat) begin
         for (int i = 0; i < NT; i++) begin
            if (live[i] && cnt[i] >= DMIN) exp_mask[i] = 1'b1;
         end
      end
      target_live = live;
      det_force = force_det;
      press(tag);
      target_live = live_after;
      if (live != '0) begin
         arm_walk(tag);
         frame_body({tag, " black"}, 1'b1, 1'b0, 0, black_n);
         if (!cheat) begin
            for (int i = 0; i < NT; i++) begin
               if (live[i]) begin
                  step();
                  frame_body($sformatf("%s flash%0d", tag, i), 1'b0, 1'b1, i, cnt[i]);
               end
            end
         end
         step();
      end
      check({tag, " hit_valid"}, 32'(hit_valid), 32'd1);
      check({tag, " hit_mask"}, 32'(hit_mask), 32'(exp_mask));
      check({tag, " miss"}, 32'(miss), 32'(exp_mask == '0));
      step();
      check({tag, " pulse end"}, 32'({hit_valid, miss, busy}), 32'b001);
      check({tag, " mask held"}, 32'(hit_mask), 32'(exp_mask));
      repeat (hold) step();
      det_force = 1'b0;
      trigger = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         step();
         n++;
      end
      check({tag, " idle"}, 32'(busy), 32'd0);
      check({tag, " one result"}, 32'(hv_count - hv0), 32'd1);
      check({tag, " one busy"}, 32'(busy_rises - br0), 32'd1);
      repeat (3) step();
   endtask

   initial begin
      int hv0, br0;
      logic [NT-1:0] lv;
      reset = 1'b0;
      trigger = 1'b0;
      detect = 1'b0;
      frame_start = 1'b0;
      target_live = '0;
      repeat (3) step();
      check("reset outputs", 32'({flash_black, flash_valid, flash_idx, hit_valid, hit_mask, miss, busy, debug}), 32'd0);
      reset = 1'b1;
      repeat (5) step();

      run_shot("single hit", 2'b11, 2'b11, 0, 0, 100, 0, 1'b0);
      run_shot("cheat", 2'b11, 2'b11, 0, 0, 0, 0, 1'b1);
      run_shot("skip dead", 2'b10, 2'b11, 0, 120, 100, 0, 1'b0);
      run_shot("no live", 2'b00, 2'b11, 0, 0, 0, 0, 1'b0);

      br0 = busy_rises;
      for (int k = 0; k < 12; k++) begin
         trigger = ~trigger;
         step();
         step();
      end
      trigger = 1'b0;
      repeat (10) step();
      check("bounce ignored", 32'(busy_rises - br0), 32'd0);
      run_shot("hold", 2'b11, 2'b01, 0, 80, 10, 3 * 4 * FRAME_LEN, 1'b0);
      run_shot("repress", 2'b01, 2'b10, 0, 90, 0, 0, 1'b0);

      run_shot("thresh 63", 2'b01, 2'b01, 0, 63, 0, 0, 1'b0);
      run_shot("thresh 64", 2'b01, 2'b01, 0, 64, 0, 0, 1'b0);
      run_shot("black 63", 2'b11, 2'b11, 63, 64, 63, 0, 1'b0);
      run_shot("black 64", 2'b11, 2'b11, 64, 100, 100, 0, 1'b0);

      target_live = 2'b11;
      press("rst mid");
      arm_walk("rst mid");
      frame_body("rst mid black", 1'b1, 1'b0, 0, 0);
      step();
      det_lo = DET_START;
      det_hi = DET_START + 100;
      repeat (50) step();
      check("rst mid in flash", 32'(flash_valid), 32'd1);
      hv0 = hv_count;
      br0 = busy_rises;
      det_lo = 0;
      det_hi = 0;
      trigger = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rst mid outputs", 32'({flash_black, flash_valid, flash_idx, hit_valid, hit_mask, miss, busy, debug}), 32'd0);
      repeat (2 * FRAME_LEN) step();
      check("rst mid no result", 32'(hv_count - hv0), 32'd0);
      check("rst mid stays idle", 32'(busy_rises - br0), 32'd0);

      for (int r = 0; r < 10; r++) begin
         int bn, c0, c1;
         lv = 2'($urandom_range(0, 3));
         bn = ($urandom_range(0, 5) == 0) ? $urandom_range(DMIN, 140) : $urandom_range(0, DMIN - 1);
         c0 = ($urandom_range(0, 2) == 0) ? $urandom_range(DMIN - 3, DMIN + 3) : $urandom_range(0, 140);
         c1 = ($urandom_range(0, 2) == 0) ? $urandom_range(DMIN - 3, DMIN + 3) : $urandom_range(0, 140);
         repeat ($urandom_range(0, FRAME_LEN - 1)) step();
         run_shot($sformatf("rand%0d", r), lv, 2'($urandom_range(0, 3)), bn, c0, c1,
                  $urandom_range(0, 20), 1'b0);
      end

      check("debug follows detect", 32'(dbg_bad), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
